// File: rtl/spm_loader.sv
// Boot loader: packs a UART byte stream big-endian into 32-bit words and fills scratchpad port B.
// Optional trailer checksum check enabled by defining SPM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start; ram_addr holds its last value
// RECV   | accepting bytes into the word shift register
// WRITE  | one-cycle write of the assembled word, then advance address/count
// CHECK  | (checksum build) waiting for the trailer byte
// FINISH | one-cycle done pulse
module spm_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef SPM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
    S_FINISH = 3'd4
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_cnt;
  logic             start_acc;
  logic             byte_xfer;

  assign start_acc = (state == S_IDLE) && start;
  assign byte_xfer = (state == S_RECV) && rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? S_FINISH : S_RECV;
        end
      end
      S_RECV: begin
        if (rx_valid && (byte_idx == 2'd3)) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (word_cnt != CNT_W'(1)) begin
          state_nxt = S_RECV;
        end else begin
`ifdef SPM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_FINISH;
`endif
        end
      end
`ifdef SPM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          state_nxt = S_FINISH;
        end
      end
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    ram_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_RECV: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        ram_we = 1'b1;
        busy   = 1'b1;
      end
`ifdef SPM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // ram_wdata doubles as the shift register; it only matters while ram_we is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
    end else begin
      if (start_acc) begin
        ram_addr <= base_addr;
        word_cnt <= word_count;
        byte_idx <= '0;
      end
      if (byte_xfer) begin
        ram_wdata <= {ram_wdata[DATA_W-9:0], rx_data};
        byte_idx  <= byte_idx + 2'd1;
      end
      if (state == S_WRITE) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        word_cnt <= word_cnt - CNT_W'(1);
      end
    end
  end

`ifdef SPM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Sum of all payload bytes plus the trailer must be 0 mod 256.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum  <= '0;
      error <= 1'b0;
    end else if (start_acc) begin
      csum  <= '0;
      error <= 1'b0;
    end else if (byte_xfer) begin
      csum <= csum + rx_data;
    end else if ((state == S_CHECK) && rx_valid) begin
      error <= (8'(rx_data + csum) != 8'h00);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_spm_loader.sv
// Randomized self-checking bench for spm_loader against a word-list reference model.
module tb_spm_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] word_count = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;
  logic        error;

  spm_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [11:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  bq[$];
  int          last_xfer_cyc = 0;
  int          last_wr_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        wq_addr.push_back(ram_addr);
        wq_data.push_back(ram_wdata);
        last_wr_cyc = cyc;
        chk("wr_rx_ready", 32'(rx_ready), 32'(0));
        chk("wr_latency", 32'(cyc), 32'(last_xfer_cyc));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = error;
        chk("done_busy", 32'(busy), 32'(0));
      end
    end
  end

  // mode: 0 = rx_valid always high, 1 = random stalls, 2 = toggle every other cycle
  task automatic send_byte(input logic [7:0] b, input int mode);
    int guard = 0;
    bit x = 1'b0;
    rx_data = b;
    while (!x) begin
      case (mode)
        1:       rx_valid = 1'($urandom_range(0, 1));
        2:       rx_valid = (cyc % 2 == 0);
        default: rx_valid = 1'b1;
      endcase
      @(negedge clk);
      x = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (x) last_xfer_cyc = cyc;
      guard++;
      if (!x && guard > 60) begin
        chk("xfer_timeout", 32'(guard), 32'(0));
        rx_valid = 1'b0;
        return;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = 12'($urandom);
    word_count = 13'($urandom);
  endtask

  task automatic run_load(input logic [11:0] b, input int n, input int mode,
                          input bit bad_trailer, input bit poke_start);
    int          start_cnt;
    int          start_cyc;
    int          g;
    logic [7:0]  sum;
    logic [7:0]  trailer;
    logic        exp_err;
    logic [11:0] ea;
    logic [31:0] ed;
    wq_addr.delete();
    wq_data.delete();
    if (bq.size() == 0)
      for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
    start_cnt = done_cnt;
    do_start(b, 13'(n));
    start_cyc = cyc;
    sum = 8'h00;
    for (int i = 0; i < bq.size(); i++) begin
      if (poke_start && i == 5) begin
        start      = 1'b1;
        base_addr  = ~b;
        word_count = 13'd7;
      end
      send_byte(bq[i], mode);
      start = 1'b0;
      sum = sum + bq[i];
    end
    exp_err = 1'b0;
`ifdef SPM_LOADER_CHECKSUM_EN
    if (n > 0) begin
      trailer = 8'h00 - sum;
      if (bad_trailer) trailer = trailer - 8'h01;
      exp_err = bad_trailer;
      send_byte(trailer, mode);
    end
`else
    trailer = sum;
`endif
    g = 0;
    while (done_cnt == start_cnt && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("done_count", 32'(done_cnt - start_cnt), 32'(1));
    chk("n_writes", 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ea = b + 12'(i);
      ed = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
      chk("wr_addr", 32'(wq_addr[i]), 32'(ea));
      chk("wr_data", wq_data[i], ed);
    end
    chk("done_error", 32'(done_err), 32'(exp_err));
    chk("error_sticky", 32'(error), 32'(exp_err));
    if (n == 0) chk("zero_done_lat", 32'(done_cyc), 32'(start_cyc));
`ifndef SPM_LOADER_CHECKSUM_EN
    else chk("done_lat", 32'(done_cyc), 32'(last_wr_cyc + 1));
`endif
    bq.delete();
  endtask

  initial begin
    logic [7:0] basic[8];
    logic [7:0] ck[4];
    basic = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    ck    = '{8'h01, 8'h02, 8'h03, 8'h04};

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      start      = 1'($urandom);
      base_addr  = 12'($urandom);
      word_count = 13'($urandom);
      rx_valid   = 1'($urandom);
      rx_data    = 8'($urandom);
      @(negedge clk);
      chk("rst_outs", {17'(ram_addr), ram_we, rx_ready, busy, done, error, 9'(0)}, 32'(0));
      chk("rst_wdata", ram_wdata, 32'(0));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'($urandom);
      @(negedge clk);
      chk("idle_outs", {17'(ram_addr), ram_we, rx_ready, busy, done, error, 9'(0)}, 32'(0));
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;

    for (int i = 0; i < 8; i++) bq.push_back(basic[i]);
    run_load(12'h010, 2, 0, 1'b0, 1'b0);

    run_load(12'hFFF, 2, 2, 1'b0, 1'b0);

    run_load(12'($urandom), 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("zero_done_clear", 32'(done), 32'(0));
    @(posedge clk);
    #1;

    run_load(12'($urandom), 3, 0, 1'b0, 1'b1);

    // mid-load reset after 6 bytes of a 3-word load
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    do_start(12'h123, 13'd3);
    for (int i = 0; i < 6; i++) send_byte(bq[i], 1);
    reset = 1'b0;
    #1;
    chk("mrst_outs", {17'(ram_addr), ram_we, rx_ready, busy, done, error, 9'(0)}, 32'(0));
    chk("mrst_wdata", ram_wdata, 32'(0));
    chk("mrst_nwr", 32'(wq_addr.size()), 32'(1));
    if (wq_addr.size() > 0) begin
      chk("mrst_addr", 32'(wq_addr[0]), 32'(12'h123));
      chk("mrst_data", wq_data[0], {bq[0], bq[1], bq[2], bq[3]});
    end
    bq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_load(12'h200, 2, 1, 1'b0, 1'b0);

    // checksum trailer good, bad, then cleared by the next start
    for (int i = 0; i < 4; i++) bq.push_back(ck[i]);
    run_load(12'h040, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bq.push_back(ck[i]);
    run_load(12'h041, 1, 0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_load(12'h000, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++)
      run_load(12'($urandom), $urandom_range(1, 5), $urandom_range(0, 2),
               1'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
